// File: rtl/score_keeper.sv
// score_keeper
// Keeps a BCD score per player from the display stage's lose flags.
// Detects the end of a match at WIN_SCORE. Drives a 4-digit multiplexed
// common-anode 7-segment display.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   lose1      async level, high = player 1 missed (point to player 2)
//   lose2      async level, high = player 2 missed (point to player 1)
//   clear      async debounced button, rising edge restarts the match
//   score1     player 1 score, BCD {tens, ones}
//   score2     player 2 score, BCD {tens, ones}
//   game_over  high while the match is over
//   winner     01 = player 1, 10 = player 2, 00 = none
//   an         digit enables, active-low
//   seg        segments {dp,g,f,e,d,c,b,a}, active-low
module score_keeper #(
  parameter int SCAN_DIV  = 25000,
  parameter int WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lose1,
  input  logic       lose2,
  input  logic       clear,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam logic [7:0]  WIN_BCD  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [19:0] SCAN_MAX = 20'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  // Saturating two-digit BCD increment (99 holds).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Common-anode segment pattern for one decimal digit, dp off.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = 8'hC0;
      4'd1:    r = 8'hF9;
      4'd2:    r = 8'hA4;
      4'd3:    r = 8'hB0;
      4'd4:    r = 8'h99;
      4'd5:    r = 8'h92;
      4'd6:    r = 8'h82;
      4'd7:    r = 8'hF8;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h90;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // Bit order in the sync vectors: {clear, lose2, lose1}.
  logic [2:0] sync1_r, sync2_r, hist_r;
  logic [2:0] ev_s;

  state_t     state_r, state_s;
  logic [7:0] score1_r, score1_s, score2_r, score2_s;
  logic [1:0] winner_r, winner_s;
  logic       game_over_r, game_over_s;

  logic [19:0] cnt_r;
  logic [1:0]  idx_r;
  logic [3:0]  an_r, an_s;
  logic [7:0]  seg_r, seg_s;
  logic [3:0]  digit_s;
  logic        blank_s, dp_s;

  // Two-flop synchronizers plus history flop. Preset to 1 so a held input gives no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      hist_r  <= 3'b111;
    end else begin
      sync1_r <= {clear, lose2, lose1};
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  assign ev_s = sync2_r & ~hist_r;

  // Match next-state. Clear beats any lose event; simultaneous lose events cancel.
  always_comb begin
    state_s     = state_r;
    score1_s    = score1_r;
    score2_s    = score2_r;
    winner_s    = winner_r;
    game_over_s = game_over_r;
    if (ev_s[2]) begin
      state_s     = ST_PLAY;
      score1_s    = 8'h00;
      score2_s    = 8'h00;
      winner_s    = 2'b00;
      game_over_s = 1'b0;
    end else if ((state_r == ST_PLAY) && (ev_s[0] ^ ev_s[1])) begin
      if (ev_s[0]) begin
        score2_s = bcd_inc(score2_r);
        if (score2_s == WIN_BCD) begin
          state_s     = ST_OVER;
          winner_s    = 2'b10;
          game_over_s = 1'b1;
        end else begin
          state_s = ST_PLAY;
        end
      end else begin
        score1_s = bcd_inc(score1_r);
        if (score1_s == WIN_BCD) begin
          state_s     = ST_OVER;
          winner_s    = 2'b01;
          game_over_s = 1'b1;
        end else begin
          state_s = ST_PLAY;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // Match state and score registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_PLAY;
      score1_r    <= 8'h00;
      score2_r    <= 8'h00;
      winner_r    <= 2'b00;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      score1_r    <= score1_s;
      score2_r    <= score2_s;
      winner_r    <= winner_s;
      game_over_r <= game_over_s;
    end
  end

  // Scan counter: digit index advances when the hold counter wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= 20'd0;
      idx_r <= 2'd0;
    end else if (cnt_r == SCAN_MAX) begin
      cnt_r <= 20'd0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + 20'd1;
      idx_r <= idx_r;
    end
  end

  // Digit select, tens blanking and winner decimal point.
  always_comb begin
    an_s    = 4'b1111;
    digit_s = 4'd0;
    blank_s = 1'b1;
    dp_s    = 1'b0;
    case (idx_r)
      2'd0: begin
        an_s    = 4'b1110;
        digit_s = score2_r[3:0];
        blank_s = 1'b0;
        dp_s    = (state_r == ST_OVER) && (winner_r == 2'b10);
      end
      2'd1: begin
        an_s    = 4'b1101;
        digit_s = score2_r[7:4];
        blank_s = (score2_r[7:4] == 4'd0);
      end
      2'd2: begin
        an_s    = 4'b1011;
        digit_s = score1_r[3:0];
        blank_s = 1'b0;
        dp_s    = (state_r == ST_OVER) && (winner_r == 2'b01);
      end
      2'd3: begin
        an_s    = 4'b0111;
        digit_s = score1_r[7:4];
        blank_s = (score1_r[7:4] == 4'd0);
      end
      default: begin
        an_s = 4'b1111;
      end
    endcase
    if (blank_s) begin
      seg_s = 8'hFF;
    end else begin
      seg_s = seg_decode(digit_s);
    end
    if (dp_s) begin
      seg_s[7] = 1'b0;
    end else begin
      seg_s[7] = seg_s[7];
    end
  end

  // Display output registers; an and seg change together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_r  <= 4'b1111;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign score1    = score1_r;
  assign score2    = score2_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;
  assign an        = an_r;
  assign seg       = seg_r;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int SCAN  = 4;
  localparam int WIN_A = 11;
  localparam int WIN_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lose1 = 1'b0, lose2 = 1'b0, clear = 1'b0;

  logic [7:0] score1_a, score2_a, seg_a, score1_b, score2_b, seg_b;
  logic       go_a, go_b;
  logic [1:0] win_a, win_b;
  logic [3:0] an_a, an_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_keeper #(.SCAN_DIV(SCAN), .WIN_SCORE(WIN_A)) u_a (
    .clk(clk), .rst(rst), .lose1(lose1), .lose2(lose2), .clear(clear),
    .score1(score1_a), .score2(score2_a), .game_over(go_a), .winner(win_a),
    .an(an_a), .seg(seg_a));

  score_keeper #(.SCAN_DIV(SCAN), .WIN_SCORE(WIN_B)) u_b (
    .clk(clk), .rst(rst), .lose1(lose1), .lose2(lose2), .clear(clear),
    .score1(score1_b), .score2(score2_b), .game_over(go_b), .winner(win_b),
    .an(an_b), .seg(seg_b));

  // ---------------- reference model (integer scores, edge history) ----------------
  int         win_tab [2] = '{WIN_A, WIN_B};
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         m_sc1 [2] = '{0, 0};
  int         m_sc2 [2] = '{0, 0};
  bit         m_over [2] = '{1'b0, 1'b0};
  logic [1:0] m_win [2] = '{2'b00, 2'b00};
  logic [3:0] m_an [2] = '{4'hF, 4'hF};
  logic [7:0] m_seg [2] = '{8'hFF, 8'hFF};
  bit         prev_l1 = 1'b1, prev_l2 = 1'b1, prev_cl = 1'b1;
  bit [2:0]   pend1 = 3'b000, pend2 = 3'b000;
  int         m_cyc = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Expected {an, seg} for digit d given one player's pair of scores.
  function automatic logic [11:0] disp(input int s1, input int s2, input bit over,
                                       input logic [1:0] w, input int d);
    logic [3:0] a;
    logic [7:0] s;
    int v;
    bit blank, dp;
    blank = 1'b0;
    dp = 1'b0;
    case (d)
      0: begin a = 4'b1110; v = s2 % 10; dp = over && (w == 2'b10); end
      1: begin a = 4'b1101; v = s2 / 10; blank = (v == 0); end
      2: begin a = 4'b1011; v = s1 % 10; dp = over && (w == 2'b01); end
      default: begin a = 4'b0111; v = s1 / 10; blank = (v == 0); end
    endcase
    s = blank ? 8'hFF : seg_tab[v];
    if (dp) s[7] = 1'b0;
    return {a, s};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sc1[k] = 0; m_sc2[k] = 0; m_over[k] = 1'b0; m_win[k] = 2'b00;
        m_an[k] = 4'hF; m_seg[k] = 8'hFF;
      end
      prev_l1 = 1'b1; prev_l2 = 1'b1; prev_cl = 1'b1;
      pend1 = 3'b000; pend2 = 3'b000;
      m_cyc = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        {m_an[k], m_seg[k]} = disp(m_sc1[k], m_sc2[k], m_over[k], m_win[k], (m_cyc / SCAN) % 4);
        if (pend2[2]) begin
          m_sc1[k] = 0; m_sc2[k] = 0; m_over[k] = 1'b0; m_win[k] = 2'b00;
        end else if (!m_over[k] && (pend2[0] != pend2[1])) begin
          if (pend2[0]) begin
            m_sc2[k] = (m_sc2[k] < 99) ? m_sc2[k] + 1 : 99;
            if (m_sc2[k] == win_tab[k]) begin m_over[k] = 1'b1; m_win[k] = 2'b10; end
          end else begin
            m_sc1[k] = (m_sc1[k] < 99) ? m_sc1[k] + 1 : 99;
            if (m_sc1[k] == win_tab[k]) begin m_over[k] = 1'b1; m_win[k] = 2'b01; end
          end
        end
      end
      m_cyc++;
      pend2 = pend1;
      pend1 = {clear & ~prev_cl, lose2 & ~prev_l2, lose1 & ~prev_l1};
      prev_l1 = lose1; prev_l2 = lose2; prev_cl = clear;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_lose2(input int n);
    repeat (n) begin
      lose2 = 1'b1; tick(1); lose2 = 1'b0; tick(2);
    end
  endtask

  task automatic test_reset;
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_seg;
    rst = 1'b0; lose1 = 1'b0; lose2 = 1'b0; clear = 1'b0;
    tick(3);
    checks++;
    if ({an_a, seg_a, score1_a, score2_a} !== {4'b1111, 8'hFF, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got an=%b seg=%h s1=%h s2=%h exp an=1111 seg=ff s1=00 s2=00",
               an_a, seg_a, score1_a, score2_a);
    end
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp_seg = ((((k - 1) / SCAN) % 2) == 0) ? 8'hC0 : 8'hFF;
      checks++;
      if (an_a !== an_seq[((k - 1) / SCAN) % 4] || seg_a !== exp_seg) begin
        failures++;
        $display("FAIL scan_cycle%0d got an=%b seg=%h exp an=%b seg=%h",
                 k, an_a, seg_a, an_seq[((k - 1) / SCAN) % 4], exp_seg);
      end
    end
  endtask

  task automatic test_single_point;
    int hits = 0;
    lose1 = 1'b1;
    tick(2);
    checks++;
    if (score2_a !== 8'h00) begin
      failures++; $display("FAIL single_latency got=%h exp=00", score2_a);
    end
    tick(1);
    checks++;
    if (score2_a !== 8'h01 || score2_b !== 8'h01) begin
      failures++; $display("FAIL single_score got=%h/%h exp=01/01", score2_a, score2_b);
    end
    for (int k = 0; k < 17; k++) begin
      tick(1);
      checks++;
      if (score2_a !== 8'h01) begin
        failures++; $display("FAIL single_held got=%h exp=01", score2_a);
      end
      if (m_an[0] == 4'b1110) begin
        hits++;
        checks++;
        if (seg_a !== 8'hF9) begin
          failures++; $display("FAIL single_seg got=%h exp=f9", seg_a);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      failures++; $display("FAIL single_seg_seen got=0 exp>0");
    end
    lose1 = 1'b0;
    tick(3);
  endtask

  task automatic test_simultaneous_bcd;
    lose1 = 1'b1; lose2 = 1'b1;
    tick(1);
    lose1 = 1'b0; lose2 = 1'b0;
    tick(5);
    checks++;
    if (score1_a !== 8'h00 || score2_a !== 8'h01) begin
      failures++; $display("FAIL simultaneous got s1=%h s2=%h exp 00 01", score1_a, score2_a);
    end
    pulse_lose2(10);
    tick(2);
    checks++;
    if (score1_a !== 8'h10) begin
      failures++; $display("FAIL bcd_carry got=%h exp=10", score1_a);
    end
    checks++;
    if ({score1_b, go_b, win_b} !== {8'h03, 1'b1, 2'b01}) begin
      failures++; $display("FAIL win_p1 got s1=%h go=%b w=%b exp 03 1 01", score1_b, go_b, win_b);
    end
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (m_an[0] == 4'b0111) begin
        checks++;
        if (seg_a !== 8'hF9) begin
          failures++; $display("FAIL tens_seg got=%h exp=f9", seg_a);
        end
      end
    end
  endtask

  task automatic test_clear;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    checks++;
    if (go_b !== 1'b1) begin
      failures++; $display("FAIL clear_latency got go=%b exp=1", go_b);
    end
    tick(1);
    checks++;
    if ({score1_b, score2_b, go_b, win_b, score1_a, score2_a} !== {8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL clear_over got b:%h %h %b %b a:%h %h exp all zero",
               score1_b, score2_b, go_b, win_b, score1_a, score2_a);
    end
  endtask

  task automatic test_win;
    int hits = 0;
    for (int i = 0; i < 3; i++) begin
      lose1 = 1'b1; tick(1); lose1 = 1'b0; tick(1);
      if (i == 2) begin
        checks++;
        if ({score2_b, go_b} !== {8'h02, 1'b0}) begin
          failures++; $display("FAIL win_before got s2=%h go=%b exp 02 0", score2_b, go_b);
        end
      end
      tick(1);
      if (i == 2) begin
        checks++;
        if ({score2_b, go_b, win_b} !== {8'h03, 1'b1, 2'b10}) begin
          failures++; $display("FAIL win_edge got s2=%h go=%b w=%b exp 03 1 10", score2_b, go_b, win_b);
        end
      end
      tick(1);
    end
    lose1 = 1'b1; tick(1); lose1 = 1'b0; tick(4);
    checks++;
    if ({score2_b, score2_a, go_a} !== {8'h03, 8'h04, 1'b0}) begin
      failures++; $display("FAIL win_frozen got b=%h a=%h go_a=%b exp 03 04 0", score2_b, score2_a, go_a);
    end
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (m_an[1] == 4'b1110) begin
        hits++;
        checks++;
        if (seg_b !== 8'h30) begin
          failures++; $display("FAIL win_dp got=%h exp=30", seg_b);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      failures++; $display("FAIL win_dp_seen got=0 exp>0");
    end
  endtask

  task automatic test_clear_lose;
    pulse_lose2(1);
    tick(2);
    clear = 1'b1; lose2 = 1'b1;
    tick(1);
    clear = 1'b0; lose2 = 1'b0;
    tick(4);
    checks++;
    if ({score1_a, score2_a, score1_b} !== {8'h00, 8'h00, 8'h00}) begin
      failures++; $display("FAIL clear_beats_lose got %h %h %h exp 00 00 00", score1_a, score2_a, score1_b);
    end
  endtask

  task automatic test_reset_mid;
    pulse_lose2(5);
    tick(2);
    checks++;
    if (score1_a !== 8'h05) begin
      failures++; $display("FAIL mid_setup got=%h exp=05", score1_a);
    end
    lose1 = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    checks++;
    if ({score1_a, score2_a, an_a} !== {8'h00, 8'h00, 4'b1111}) begin
      failures++; $display("FAIL mid_reset got s1=%h s2=%h an=%b exp 00 00 1111", score1_a, score2_a, an_a);
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if (score2_a !== 8'h00 || score1_a !== 8'h00) begin
        failures++; $display("FAIL mid_held got s1=%h s2=%h exp 00 00", score1_a, score2_a);
      end
    end
    lose1 = 1'b0;
    tick(3);
  endtask

  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) lose1 = ~lose1;
      if ($urandom_range(0, 3) == 0) lose2 = ~lose2;
      if ($urandom_range(0, 59) == 0) clear = ~clear;
      rst = ($urandom_range(0, 299) != 0);
      tick(1);
      checks++;
      if ({score1_a, score2_a, go_a, win_a, an_a, seg_a} !==
          {to_bcd(m_sc1[0]), to_bcd(m_sc2[0]), m_over[0], m_win[0], m_an[0], m_seg[0]}) begin
        failures++;
        $display("FAIL rand_a cyc%0d got s1=%h s2=%h go=%b w=%b an=%b seg=%h exp s1=%h s2=%h go=%b w=%b an=%b seg=%h",
                 k, score1_a, score2_a, go_a, win_a, an_a, seg_a,
                 to_bcd(m_sc1[0]), to_bcd(m_sc2[0]), m_over[0], m_win[0], m_an[0], m_seg[0]);
      end
      checks++;
      if ({score1_b, score2_b, go_b, win_b, an_b, seg_b} !==
          {to_bcd(m_sc1[1]), to_bcd(m_sc2[1]), m_over[1], m_win[1], m_an[1], m_seg[1]}) begin
        failures++;
        $display("FAIL rand_b cyc%0d got s1=%h s2=%h go=%b w=%b an=%b seg=%h exp s1=%h s2=%h go=%b w=%b an=%b seg=%h",
                 k, score1_b, score2_b, go_b, win_b, an_b, seg_b,
                 to_bcd(m_sc1[1]), to_bcd(m_sc2[1]), m_over[1], m_win[1], m_an[1], m_seg[1]);
      end
    end
    rst = 1'b1; lose1 = 1'b0; lose2 = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_point;
    test_simultaneous_bcd;
    test_clear;
    test_win;
    test_clear_lose;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
